// File: rtl/t05_cb_sequencer.sv
// Codebook-synthesis sequencer: fetches htree nodes for the walker, steps it, and writes found leaves to the codebook.
// Optional handshake watchdog is built when T05_CB_SEQ_TIMEOUT_EN is defined.
module t05_cb_sequencer #(
    parameter int IDX_W   = 7,
    parameter int ELEM_W  = 71,
    parameter int CHAR_W  = 8,
    parameter int PATH_W  = 128,
    parameter int LEN_W   = 7,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  max_index,
    input  logic [IDX_W-1:0]  walk_index,
    input  logic              walk_char_found,
    input  logic [CHAR_W-1:0] walk_char_index,
    input  logic [PATH_W-1:0] walk_char_path,
    input  logic [LEN_W-1:0]  walk_track_length,
    input  logic              walk_finished,
    output logic              walk_en,
    output logic [ELEM_W-1:0] h_element,
    output logic [IDX_W-1:0]  max_index_o,
    output logic              mem_rd_req,
    output logic [IDX_W-1:0]  mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [ELEM_W-1:0] mem_rd_data,
    output logic              cb_wr_req,
    output logic [CHAR_W-1:0] cb_wr_char,
    output logic [PATH_W-1:0] cb_wr_path,
    output logic [LEN_W-1:0]  cb_wr_len,
    input  logic              cb_wr_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        chars_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_STEP,
        S_EVAL,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_walk_en;
    logic [ELEM_W-1:0]   r_h_element;
    logic [IDX_W-1:0]    r_max_index;
    logic                r_mem_rd_req;
    logic [IDX_W-1:0]    r_mem_rd_addr;
    logic                r_cb_wr_req;
    logic [CHAR_W-1:0]   r_cb_wr_char;
    logic [PATH_W-1:0]   r_cb_wr_path;
    logic [LEN_W-1:0]    r_cb_wr_len;
    logic                r_busy;
    logic                r_done;
    logic                r_fin_pend;
    logic [7:0]          r_chars_written;

`ifdef T05_CB_SEQ_TIMEOUT_EN
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
    logic                r_err;
    logic [7:0]          r_wd_cnt;
    assign err = r_err;
`else
    logic [31:0]         w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT);
    assign err = 1'b0;
`endif

    // NOTE: the whole datapath is reset asynchronously so an rst mid-pass clears every output at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_walk_en       <= 1'b0;
            r_h_element     <= '0;
            r_max_index     <= '0;
            r_mem_rd_req    <= 1'b0;
            r_mem_rd_addr   <= '0;
            r_cb_wr_req     <= 1'b0;
            r_cb_wr_char    <= '0;
            r_cb_wr_path    <= '0;
            r_cb_wr_len     <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_fin_pend      <= 1'b0;
            r_chars_written <= '0;
`ifdef T05_CB_SEQ_TIMEOUT_EN
            r_err           <= 1'b0;
            r_wd_cnt        <= '0;
`endif
        end else begin
`ifdef T05_CB_SEQ_TIMEOUT_EN
            // The watchdog only accumulates while waiting on a handshake.
            if (r_state != S_FETCH && r_state != S_EMIT) begin
                r_wd_cnt <= '0;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_max_index     <= max_index;
                        r_chars_written <= '0;
                        r_fin_pend      <= 1'b0;
                        r_busy          <= 1'b1;
                        r_mem_rd_req    <= 1'b1;
                        r_mem_rd_addr   <= walk_index;
                        r_state         <= S_FETCH;
`ifdef T05_CB_SEQ_TIMEOUT_EN
                        r_err           <= 1'b0;
`endif
                    end
                end

                S_FETCH: begin
                    if (r_mem_rd_req && mem_rd_ack) begin
                        r_h_element  <= mem_rd_data;
                        r_mem_rd_req <= 1'b0;
                        r_walk_en    <= 1'b1;
                        r_state      <= S_STEP;
`ifdef T05_CB_SEQ_TIMEOUT_EN
                        r_wd_cnt     <= '0;
                    end else if (r_wd_cnt >= WD_LIMIT) begin
                        r_mem_rd_req <= 1'b0;
                        r_err        <= 1'b1;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_wd_cnt     <= r_wd_cnt + 8'd1;
`endif
                    end
                end

                S_STEP: begin
                    r_walk_en <= 1'b0;
                    r_state   <= S_EVAL;
                end

                S_EVAL: begin
                    if (walk_char_found) begin
                        r_cb_wr_char <= walk_char_index;
                        r_cb_wr_path <= walk_char_path;
                        r_cb_wr_len  <= walk_track_length;
                        r_cb_wr_req  <= 1'b1;
                        if (walk_finished) begin
                            r_fin_pend <= 1'b1;
                        end
                        r_state      <= S_EMIT;
                    end else if (walk_finished) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_mem_rd_req  <= 1'b1;
                        r_mem_rd_addr <= walk_index;
                        r_state       <= S_FETCH;
                    end
                end

                S_EMIT: begin
                    if (r_cb_wr_req && cb_wr_ack) begin
                        r_cb_wr_req <= 1'b0;
                        if (r_chars_written != 8'hFF) begin
                            r_chars_written <= r_chars_written + 8'd1;
                        end
                        if (r_fin_pend) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_mem_rd_req  <= 1'b1;
                            r_mem_rd_addr <= walk_index;
                            r_state       <= S_FETCH;
                        end
`ifdef T05_CB_SEQ_TIMEOUT_EN
                        r_wd_cnt    <= '0;
                    end else if (r_wd_cnt >= WD_LIMIT) begin
                        r_cb_wr_req <= 1'b0;
                        r_err       <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_wd_cnt    <= r_wd_cnt + 8'd1;
`endif
                    end
                end

                S_DONE: begin
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_fin_pend <= 1'b0;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_walk_en    <= 1'b0;
                    r_mem_rd_req <= 1'b0;
                    r_cb_wr_req  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign walk_en       = r_walk_en;
    assign h_element     = r_h_element;
    assign max_index_o   = r_max_index;
    assign mem_rd_req    = r_mem_rd_req;
    assign mem_rd_addr   = r_mem_rd_addr;
    assign cb_wr_req     = r_cb_wr_req;
    assign cb_wr_char    = r_cb_wr_char;
    assign cb_wr_path    = r_cb_wr_path;
    assign cb_wr_len     = r_cb_wr_len;
    assign busy          = r_busy;
    assign done          = r_done;
    assign chars_written = r_chars_written;

endmodule

// File: tb/tb_t05_cb_sequencer.sv
// Self-checking bench for t05_cb_sequencer: scripted walker, htree memory and codebook responders with a write scoreboard.
module tb_t05_cb_sequencer;

    localparam int IDX_W   = 7;
    localparam int ELEM_W  = 71;
    localparam int CHAR_W  = 8;
    localparam int PATH_W  = 128;
    localparam int LEN_W   = 7;
    localparam int NSCR    = 300;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IDX_W-1:0]  max_index;
    logic [IDX_W-1:0]  walk_index;
    logic              walk_char_found;
    logic [CHAR_W-1:0] walk_char_index;
    logic [PATH_W-1:0] walk_char_path;
    logic [LEN_W-1:0]  walk_track_length;
    logic              walk_finished;
    logic              walk_en;
    logic [ELEM_W-1:0] h_element;
    logic [IDX_W-1:0]  max_index_o;
    logic              mem_rd_req;
    logic [IDX_W-1:0]  mem_rd_addr;
    logic              mem_rd_ack;
    logic [ELEM_W-1:0] mem_rd_data;
    logic              cb_wr_req;
    logic [CHAR_W-1:0] cb_wr_char;
    logic [PATH_W-1:0] cb_wr_path;
    logic [LEN_W-1:0]  cb_wr_len;
    logic              cb_wr_ack;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        chars_written;

    always #5 clk = ~clk;

    t05_cb_sequencer #(
        .IDX_W(IDX_W), .ELEM_W(ELEM_W), .CHAR_W(CHAR_W),
        .PATH_W(PATH_W), .LEN_W(LEN_W), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .max_index(max_index),
        .walk_index(walk_index), .walk_char_found(walk_char_found),
        .walk_char_index(walk_char_index), .walk_char_path(walk_char_path),
        .walk_track_length(walk_track_length), .walk_finished(walk_finished),
        .walk_en(walk_en), .h_element(h_element), .max_index_o(max_index_o),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .cb_wr_req(cb_wr_req), .cb_wr_char(cb_wr_char),
        .cb_wr_path(cb_wr_path), .cb_wr_len(cb_wr_len), .cb_wr_ack(cb_wr_ack),
        .busy(busy), .done(done), .err(err), .chars_written(chars_written)
    );

    typedef struct packed {
        logic [CHAR_W-1:0] ch;
        logic [PATH_W-1:0] path;
        logic [LEN_W-1:0]  len;
    } wr_t;

    int  n_vec = 0;
    int  n_err = 0;
    wr_t exp_q[$];
    wr_t exp_w;
    wr_t wr_seen;

    // Walker script: one entry per walk_en step.
    logic [IDX_W-1:0]  scr_idx   [NSCR];
    bit                scr_found [NSCR];
    logic [CHAR_W-1:0] scr_char  [NSCR];
    logic [PATH_W-1:0] scr_path  [NSCR];
    logic [LEN_W-1:0]  scr_len   [NSCR];
    bit                scr_fin   [NSCR];
    int n_steps = 0;
    int n_found = 0;
    int s = 0;

    int rd_delay = 0, wr_delay = 0, rd_wait = 0, wr_wait = 0;
    bit rd_busy = 0, wr_busy = 0, walk_en_prev = 0, done_prev = 0;
    logic [IDX_W-1:0] rd_addr_seen;
    int acks = 0, walk_ens = 0, writes = 0, done_cnt = 0, rd_req_cycles = 0;

    function automatic logic [ELEM_W-1:0] mem_f(input logic [IDX_W-1:0] a);
        logic [63:0] m;
        m = 64'(a) * 64'h9E37_79B9_7F4A_7C15;
        return {a, m ^ 64'h0123_4567_89AB_CDEF};
    endfunction

    function automatic logic [241:0] outs();
        return {walk_en, h_element, max_index_o, mem_rd_req, mem_rd_addr, cb_wr_req,
                cb_wr_char, cb_wr_path, cb_wr_len, busy, done, err, chars_written};
    endfunction

    // Responders and walker model, evaluated on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            mem_rd_ack = 1'b0;
            cb_wr_ack = 1'b0;
            rd_busy = 0;
            wr_busy = 0;
            walk_en_prev = 0;
            done_prev = 0;
        end else begin
            if (mem_rd_req) rd_req_cycles++;
            // htree read port
            if (mem_rd_ack) begin
                mem_rd_ack = 1'b0;
                mem_rd_data = ELEM_W'({$urandom(), $urandom(), $urandom()});
                rd_busy = 0;
                n_vec++;
                if (walk_en !== 1'b1 || mem_rd_req !== 1'b0) begin
                    $display("FAIL rd_ack_to_walk_en: walk_en=%b mem_rd_req=%b, want 1/0", walk_en, mem_rd_req);
                    n_err++;
                end
            end else if (mem_rd_req) begin
                n_vec++;
                if (!rd_busy) begin
                    rd_busy = 1;
                    rd_wait = 0;
                    rd_addr_seen = mem_rd_addr;
                    if (mem_rd_addr !== walk_index) begin
                        $display("FAIL rd_addr: got %0d want %0d", mem_rd_addr, walk_index);
                        n_err++;
                    end
                end else if (mem_rd_addr !== rd_addr_seen) begin
                    $display("FAIL rd_addr_stable: got %0d want %0d", mem_rd_addr, rd_addr_seen);
                    n_err++;
                end
                if (rd_wait >= rd_delay) begin
                    mem_rd_ack = 1'b1;
                    mem_rd_data = mem_f(mem_rd_addr);
                    acks++;
                end else begin
                    rd_wait++;
                end
            end else begin
                rd_busy = 0;
            end

            // walker
            if (walk_en) begin
                walk_ens++;
                n_vec += 2;
                if (walk_en_prev) begin
                    $display("FAIL walk_en_width: got 2+ cycles want 1");
                    n_err++;
                end
                if (h_element !== mem_f(walk_index)) begin
                    $display("FAIL h_element: got %h want %h", h_element, mem_f(walk_index));
                    n_err++;
                end
                if (s >= n_steps) begin
                    $display("FAIL walker_overrun: step %0d of %0d", s, n_steps);
                    n_err++;
                end else begin
                    walk_char_found   = scr_found[s];
                    walk_char_index   = scr_char[s];
                    walk_char_path    = scr_path[s];
                    walk_track_length = scr_len[s];
                    walk_finished     = scr_fin[s];
                    if (scr_found[s]) exp_q.push_back({scr_char[s], scr_path[s], scr_len[s]});
                    s++;
                    if (s < n_steps) walk_index = scr_idx[s];
                end
            end
            walk_en_prev = walk_en;

            // codebook write port
            if (cb_wr_ack) begin
                cb_wr_ack = 1'b0;
                wr_busy = 0;
                n_vec++;
                if (cb_wr_req !== 1'b0) begin
                    $display("FAIL wr_req_drop: got %b want 0", cb_wr_req);
                    n_err++;
                end
            end else if (cb_wr_req) begin
                if (!wr_busy) begin
                    wr_busy = 1;
                    wr_wait = 0;
                    wr_seen = {cb_wr_char, cb_wr_path, cb_wr_len};
                end else begin
                    n_vec++;
                    if ({cb_wr_char, cb_wr_path, cb_wr_len} !== wr_seen) begin
                        $display("FAIL wr_stable: got %h want %h", {cb_wr_char, cb_wr_path, cb_wr_len}, wr_seen);
                        n_err++;
                    end
                end
                if (wr_wait >= wr_delay) begin
                    cb_wr_ack = 1'b1;
                    writes++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL wr_unexpected: char %0d, want no write", cb_wr_char);
                        n_err++;
                    end else begin
                        exp_w = exp_q.pop_front();
                        if ({cb_wr_char, cb_wr_path, cb_wr_len} !== exp_w) begin
                            $display("FAIL wr_data: got %h want %h", {cb_wr_char, cb_wr_path, cb_wr_len}, exp_w);
                            n_err++;
                        end
                    end
                end else begin
                    wr_wait++;
                end
            end else begin
                wr_busy = 0;
            end

            // done pulse monitor
            if (done) begin
                done_cnt++;
                n_vec++;
                if (done_prev) begin
                    $display("FAIL done_width: got 2+ cycles want 1");
                    n_err++;
                end
            end
            done_prev = done;
        end
    end

    task automatic script_clear();
        n_steps = 0;
        n_found = 0;
    endtask

    task automatic add_step(input logic [IDX_W-1:0] idx, input bit f, input logic [CHAR_W-1:0] ch,
                            input logic [PATH_W-1:0] p, input logic [LEN_W-1:0] l, input bit fin);
        scr_idx[n_steps]   = idx;
        scr_found[n_steps] = f;
        scr_char[n_steps]  = ch;
        scr_path[n_steps]  = p;
        scr_len[n_steps]   = l;
        scr_fin[n_steps]   = fin;
        n_steps++;
        if (f) n_found++;
    endtask

    task automatic reset_models();
        s = 0;
        walk_index = scr_idx[0];
        walk_char_found = 1'b0;
        walk_finished = 1'b0;
        walk_char_index = '0;
        walk_char_path = '0;
        walk_track_length = '0;
        exp_q.delete();
        rd_busy = 0;
        wr_busy = 0;
        mem_rd_ack = 1'b0;
        cb_wr_ack = 1'b0;
        walk_en_prev = 0;
        done_prev = 0;
    endtask

    task automatic build_tree();
        script_clear();
        for (int k = 0; k < 9; k++) begin
            add_step(7'(18 - k), 0, '0, '0, '0, 0);
            add_step(7'(k), 1, 8'(65 + k), 128'((1 << (k + 1)) - 2), 7'(k + 1), 0);
        end
        add_step(7'd9, 1, 8'd74, 128'((1 << 9) - 1), 7'd9, 0);
        add_step(7'd18, 0, '0, '0, '0, 1);
    endtask

    task automatic run_pass(input string name, input logic [IDX_W-1:0] mi, input bit poke);
        int d0, a0, w0, wr0, budget;
        bit got;
        logic [7:0] exp_cw;
        reset_models();
        d0 = done_cnt; a0 = acks; w0 = walk_ens; wr0 = writes;
        budget = 200 + n_steps * (40 + 2 * rd_delay + 2 * wr_delay);
        exp_cw = (n_found > 255) ? 8'd255 : 8'(n_found);
        @(negedge clk); #1;
        max_index = mi;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        max_index = ~mi;
        n_vec++;
        if (mem_rd_req !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL %s start_latency: req=%b busy=%b want 1/1", name, mem_rd_req, busy);
            n_err++;
        end
        got = 0;
        for (int c = 0; c < budget; c++) begin
            if (done_cnt != d0) begin
                got = 1;
                break;
            end
            if (poke && c == 2) begin
                start = 1'b1;
                max_index = 7'd99;
            end
            if (poke && c == 3) start = 1'b0;
            @(negedge clk); #1;
        end
        start = 1'b0;
        n_vec++;
        if (!got) begin
            $display("FAIL %s done_timeout: no done within %0d cycles", name, budget);
            n_err++;
        end
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b1 || err !== 1'b0 || max_index_o !== mi) begin
            $display("FAIL %s done_state: busy=%b done=%b err=%b max_index_o=%0d want 1/1/0/%0d",
                     name, busy, done, err, max_index_o, mi);
            n_err++;
        end
        n_vec++;
        if (chars_written !== exp_cw) begin
            $display("FAIL %s chars_written: got %0d want %0d", name, chars_written, exp_cw);
            n_err++;
        end
        n_vec++;
        if (writes - wr0 != n_found || exp_q.size() != 0) begin
            $display("FAIL %s write_count: got %0d want %0d (pending %0d)", name, writes - wr0, n_found, exp_q.size());
            n_err++;
        end
        n_vec++;
        if (walk_ens - w0 != acks - a0) begin
            $display("FAIL %s walk_en_per_fetch: got %0d steps want %0d", name, walk_ens - w0, acks - a0);
            n_err++;
        end
        @(negedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL %s idle_after_done: busy=%b done=%b want 0/0", name, busy, done);
            n_err++;
        end
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (done_cnt != d0 + 1) begin
            $display("FAIL %s done_count: got %0d want 1", name, done_cnt - d0);
            n_err++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if (outs() !== '0) begin
            $display("FAIL reset_outputs: got %h want 0", outs());
            n_err++;
        end
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        n_vec++;
        if (outs() !== '0) begin
            $display("FAIL idle_outputs: got %h want 0", outs());
            n_err++;
        end
    endtask

    task automatic test_single_leaf();
        script_clear();
        add_step(7'd0, 1, 8'd67, 128'd0, 7'd1, 0);
        add_step(7'd0, 0, '0, '0, '0, 1);
        rd_delay = 0;
        wr_delay = 0;
        run_pass("single_leaf", 7'd0, 0);
    endtask

    task automatic test_backpressure();
        script_clear();
        add_step(7'd4, 0, '0, '0, '0, 0);
        add_step(7'd1, 1, 8'd120, 128'b10, 7'd2, 0);
        add_step(7'd2, 1, 8'd121, 128'b11, 7'd2, 0);
        add_step(7'd0, 1, 8'd122, 128'b0, 7'd1, 0);
        add_step(7'd4, 0, '0, '0, '0, 1);
        rd_delay = 3;
        wr_delay = 5;
        run_pass("backpressure", 7'd4, 0);
    endtask

    task automatic test_tree();
        build_tree();
        rd_delay = 1;
        wr_delay = 0;
        run_pass("tree", 7'd18, 0);
    endtask

    task automatic test_rst_midpass();
        bit hit;
        build_tree();
        reset_models();
        rd_delay = 1;
        wr_delay = 2;
        @(negedge clk); #1;
        max_index = 7'd18;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 1000; c++) begin
            if (walk_index == 7'd9) begin
                hit = 1;
                break;
            end
            @(negedge clk); #1;
        end
        n_vec++;
        if (!hit || busy !== 1'b1) begin
            $display("FAIL rst_mid_reach: hit=%b busy=%b want 1/1", hit, busy);
            n_err++;
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (outs() !== '0) begin
            $display("FAIL rst_mid_outputs: got %h want 0", outs());
            n_err++;
        end
        reset_models();
        #1;
        rst = 1'b0;
        run_pass("after_rst", 7'd18, 0);
    endtask

    task automatic test_found_and_finished();
        script_clear();
        add_step(7'd0, 1, 8'd90, 128'd5, 7'd3, 1);
        rd_delay = 4;
        wr_delay = 2;
        run_pass("found_and_finished", 7'd0, 1);
    endtask

    task automatic test_saturate();
        script_clear();
        for (int i = 0; i < 260; i++) begin
            add_step(7'(i), 1, 8'(i), 128'(i), 7'(i % 127 + 1), i == 259);
        end
        rd_delay = 0;
        wr_delay = 0;
        run_pass("saturate", 7'd127, 0);
    endtask

`ifdef T05_CB_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int d0, r0;
        bit got;
        script_clear();
        add_step(7'd0, 1, 8'd67, 128'd0, 7'd1, 1);
        reset_models();
        rd_delay = 100000;
        d0 = done_cnt;
        r0 = rd_req_cycles;
        @(negedge clk); #1;
        max_index = 7'd0;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 600; c++) begin
            if (done_cnt != d0) begin
                got = 1;
                break;
            end
            @(negedge clk); #1;
        end
        n_vec++;
        if (!got || rd_req_cycles - r0 != 256) begin
            $display("FAIL timeout_req_cycles: done=%b req cycles %0d want 256", got, rd_req_cycles - r0);
            n_err++;
        end
        n_vec++;
        if (err !== 1'b1 || mem_rd_req !== 1'b0 || chars_written !== 8'd0) begin
            $display("FAIL timeout_state: err=%b req=%b cw=%0d want 1/0/0", err, mem_rd_req, chars_written);
            n_err++;
        end
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL timeout_sticky: err=%b busy=%b want 1/0", err, busy);
            n_err++;
        end
        test_single_leaf();
    endtask
`else
    task automatic test_timeout();
        int r0;
        script_clear();
        add_step(7'd0, 1, 8'd67, 128'd0, 7'd1, 0);
        add_step(7'd0, 0, '0, '0, '0, 1);
        rd_delay = 300;
        wr_delay = 0;
        r0 = rd_req_cycles;
        run_pass("long_wait", 7'd0, 0);
        n_vec++;
        if (rd_req_cycles - r0 != 2 * 301) begin
            $display("FAIL long_wait_req_cycles: got %0d want %0d", rd_req_cycles - r0, 2 * 301);
            n_err++;
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        max_index = '0;
        walk_index = '0;
        walk_char_found = 1'b0;
        walk_char_index = '0;
        walk_char_path = '0;
        walk_track_length = '0;
        walk_finished = 1'b0;
        mem_rd_ack = 1'b0;
        mem_rd_data = '0;
        cb_wr_ack = 1'b0;
        test_reset();
        test_single_leaf();
        test_backpressure();
        test_tree();
        test_rst_midpass();
        test_found_and_finished();
        test_saturate();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
